// File: rtl/vliw_banked_memory.sv
// vliw_banked_memory: multi-lane, banked, word-addressed data memory.
// Each VLIW memory lane issues one request per cycle over a valid/ready handshake.
// Lanes that target the same bank are arbitrated by a rotating priority pointer.
// Losing lanes stall and hold their request.
// Reads return data one cycle after acceptance; writes are byte-enabled and silent.
module vliw_banked_memory #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 4,
  parameter int NUM_LANES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            req_valid,
  output logic [NUM_LANES-1:0]            req_ready,
  input  logic [NUM_LANES-1:0]            req_we,
  input  logic [NUM_LANES*ADDR_W-1:0]     req_addr,
  input  logic [NUM_LANES*DATA_W-1:0]     req_wdata,
  input  logic [NUM_LANES*(DATA_W/8)-1:0] req_be,
  output logic [NUM_LANES-1:0]            rsp_valid,
  output logic [NUM_LANES*DATA_W-1:0]     rsp_rdata
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int ROWS   = 1 << ROW_W;
  localparam int PRIO_W = $clog2(NUM_LANES);

  // Storage: one independent array per bank; arbitration guarantees one lane per bank per cycle.
  logic [DATA_W-1:0] r_mem [NUM_BANKS][ROWS];

  logic [PRIO_W-1:0]         r_prio;
  logic [NUM_LANES-1:0]      r_rsp_valid;
  logic [NUM_LANES*DATA_W-1:0] r_rsp_rdata;

  logic [BANK_W-1:0]    w_bank [NUM_LANES];
  logic [ROW_W-1:0]     w_row  [NUM_LANES];
  logic [PRIO_W-1:0]    w_rank [NUM_LANES];
  logic [NUM_LANES-1:0] w_grant;
  logic [NUM_LANES-1:0] w_accept;
  logic                 w_stall;

  // Split each lane address into bank select (low bits) and row, and rank the lane
  // by its distance from the priority pointer (rank 0 = highest priority).
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_bank[i] = req_addr[i*ADDR_W +: BANK_W];
      w_row[i]  = req_addr[i*ADDR_W + BANK_W +: ROW_W];
      w_rank[i] = PRIO_W'((i + NUM_LANES - int'(r_prio)) % NUM_LANES);
    end
  end

  // Grant a valid lane unless a better-ranked valid lane targets the same bank.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    w_grant = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_grant[i] = req_valid[i];
      for (int j = 0; j < NUM_LANES; j++) begin
        if (j != i && req_valid[j] && (w_bank[j] == w_bank[i]) && (w_rank[j] < w_rank[i])) begin
          w_grant[i] = 1'b0;
        end
      end
    end
  end

  // Idle lanes are always ready; nothing is accepted while reset is held.
  assign req_ready = rst ? '0 : (~req_valid | w_grant);
  assign w_accept  = req_valid & req_ready;
  assign w_stall   = |(req_valid & ~req_ready);

  // Byte-enabled writes into the addressed bank row.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; only control state is cleared, so the arrays can map to RAM.
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int k = 0; k < BYTES; k++) begin
        if (w_accept[i] && req_we[i] && req_be[i*BYTES + k]) begin
          r_mem[w_bank[i]][w_row[i]][k*8 +: 8] <= req_wdata[i*DATA_W + k*8 +: 8];
        end
      end
    end
  end

  // Read responses, one cycle after acceptance, plus rotation of the priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_prio      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_rsp_valid <= w_accept & ~req_we;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_accept[i] && !req_we[i]) begin
          r_rsp_rdata[i*DATA_W +: DATA_W] <= r_mem[w_bank[i]][w_row[i]];
        end
      end
      if (w_stall) begin
        r_prio <= (r_prio == PRIO_W'(NUM_LANES - 1)) ? '0 : r_prio + 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_vliw_banked_memory.sv
// Self-checking bench for vliw_banked_memory.
// A reference model predicts ready, memory contents and the priority pointer.
// Expected read data is queued per lane at acceptance and popped when the response appears.
module tb_vliw_banked_memory;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int NUM_BANKS = 4;
  localparam int NUM_LANES = 2;
  localparam int BYTES     = DATA_W / 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_LANES-1:0]          req_valid;
  logic [NUM_LANES-1:0]          req_ready;
  logic [NUM_LANES-1:0]          req_we;
  logic [NUM_LANES*ADDR_W-1:0]   req_addr;
  logic [NUM_LANES*DATA_W-1:0]   req_wdata;
  logic [NUM_LANES*BYTES-1:0]    req_be;
  logic [NUM_LANES-1:0]          rsp_valid;
  logic [NUM_LANES*DATA_W-1:0]   rsp_rdata;

  always #5 clk = ~clk;

  vliw_banked_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .NUM_LANES(NUM_LANES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0]    mem_m   [1 << ADDR_W];
  logic [DATA_W-1:0]    exp_q   [NUM_LANES][$];
  logic [DATA_W-1:0]    last_rd [NUM_LANES];
  int                   mprio   = 0;
  logic [NUM_LANES-1:0] last_acc;

  task automatic set_lane(input int i, input logic v, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BYTES-1:0] be);
    req_valid[i]                  = v;
    req_we[i]                     = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_be[i*BYTES +: BYTES]      = be;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
  endtask

  // Walk lanes from the priority pointer; the first valid lane to claim a bank wins it.
  function automatic logic [NUM_LANES-1:0] model_ready();
    logic [NUM_BANKS-1:0] taken;
    logic [NUM_LANES-1:0] r;
    logic [ADDR_W-1:0]    a;
    int lane, bank;
    if (rst) return '0;
    r     = ~req_valid;
    taken = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane = (mprio + k) % NUM_LANES;
      if (req_valid[lane]) begin
        a    = req_addr[lane*ADDR_W +: ADDR_W];
        bank = int'(a) % NUM_BANKS;
        if (!taken[bank]) begin
          r[lane]     = 1'b1;
          taken[bank] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // One clock cycle: check ready against the model, update the model, then check responses.
  task automatic step(input string tag);
    logic [NUM_LANES-1:0] er, erv;
    logic [ADDR_W-1:0]    a;
    logic [DATA_W-1:0]    got, want;
    logic                 rst_s;
    #1;
    er    = model_ready();
    rst_s = rst;
    vectors++;
    if (req_ready !== er) begin
      miscompares++;
      $display("FAIL %s ready: got %b expected %b", tag, req_ready, er);
    end
    erv      = '0;
    last_acc = req_valid & er;
    if (rst_s) begin
      mprio = 0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (last_acc[i] && !req_we[i]) begin
          a = req_addr[i*ADDR_W +: ADDR_W];
          exp_q[i].push_back(mem_m[a]);
          erv[i] = 1'b1;
        end
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (last_acc[i] && req_we[i]) begin
          a = req_addr[i*ADDR_W +: ADDR_W];
          for (int b = 0; b < BYTES; b++) begin
            if (req_be[i*BYTES + b]) mem_m[a][b*8 +: 8] = req_wdata[i*DATA_W + b*8 +: 8];
          end
        end
      end
      if (|(req_valid & ~er)) mprio = (mprio + 1) % NUM_LANES;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (rsp_valid !== erv) begin
      miscompares++;
      $display("FAIL %s rsp_valid: got %b expected %b", tag, rsp_valid, erv);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      got = rsp_rdata[i*DATA_W +: DATA_W];
      if (rst_s) begin
        last_rd[i] = '0;
        vectors++;
        if (got !== '0) begin
          miscompares++;
          $display("FAIL %s reset rdata lane%0d: got %h expected 0", tag, i, got);
        end
      end else if (erv[i] || rsp_valid[i]) begin
        vectors++;
        if (exp_q[i].size() == 0) begin
          miscompares++;
          $display("FAIL %s unexpected response lane%0d: got %h, nothing outstanding", tag, i, got);
        end else begin
          want       = exp_q[i].pop_front();
          last_rd[i] = want;
          if (got !== want) begin
            miscompares++;
            $display("FAIL %s rdata lane%0d: got %h expected %h", tag, i, got, want);
          end
        end
      end else begin
        vectors++;
        if (got !== last_rd[i]) begin
          miscompares++;
          $display("FAIL %s rdata hold lane%0d: got %h expected %h", tag, i, got, last_rd[i]);
        end
      end
    end
  endtask

  // Keep stepping until every pending request is accepted; stalled lanes hold their request.
  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while (req_valid != '0 && n < max_cycles) begin
      step(tag);
      req_valid = req_valid & ~last_acc;
      n++;
    end
    if (req_valid != '0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s drain timeout: pending %b expected 00", tag, req_valid);
      idle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("idle_after_reset");
  endtask

  task automatic test_parallel();
    set_lane(0, 1'b1, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    set_lane(1, 1'b1, 1'b1, 8'h05, 32'h12345678, 4'hF);
    step("parallel_wr");
    set_lane(0, 1'b1, 1'b0, 8'h04, '0, '0);
    set_lane(1, 1'b1, 1'b0, 8'h05, '0, '0);
    step("parallel_rd");
    vectors++;
    if (rsp_rdata !== {32'h12345678, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL parallel_const: got %h expected %h", rsp_rdata, {32'h12345678, 32'hDEADBEEF});
    end
    idle();
    step("parallel_idle");
  endtask

  task automatic test_byte_enables();
    set_lane(0, 1'b1, 1'b1, 8'h10, 32'hFFFFFFFF, 4'hF);
    step("be_full");
    set_lane(0, 1'b1, 1'b1, 8'h10, 32'h000000AA, 4'b0001);
    step("be_byte0");
    set_lane(0, 1'b1, 1'b1, 8'h10, 32'h12345678, 4'b0000);
    step("be_noop");
    set_lane(0, 1'b1, 1'b0, 8'h10, '0, '0);
    step("be_read");
    vectors++;
    if (rsp_rdata[DATA_W-1:0] !== 32'hFFFFFFAA) begin
      miscompares++;
      $display("FAIL be_const: got %h expected FFFFFFAA", rsp_rdata[DATA_W-1:0]);
    end
    idle();
    step("be_idle");
  endtask

  task automatic test_conflict();
    set_lane(0, 1'b1, 1'b1, 8'h08, 32'hA5A5_0008, 4'hF);
    step("cf_setup0");
    set_lane(0, 1'b1, 1'b1, 8'h0C, 32'h5A5A_000C, 4'hF);
    step("cf_setup1");
    idle();
    set_lane(0, 1'b1, 1'b0, 8'h08, '0, '0);
    set_lane(1, 1'b1, 1'b0, 8'h0C, '0, '0);
    step("cf_cycle1");
    set_lane(0, 1'b1, 1'b0, 8'h08, '0, '0);
    step("cf_cycle2");
    req_valid = req_valid & ~last_acc;
    step("cf_cycle3");
    req_valid = req_valid & ~last_acc;
    drain("cf_drain", 4);
    // Same-address write and read in one cycle: they share a bank, so one must wait.
    set_lane(0, 1'b1, 1'b1, 8'h30, 32'hC0FFEE00, 4'hF);
    set_lane(1, 1'b1, 1'b0, 8'h30, '0, '0);
    drain("cf_rw_same", 4);
    set_lane(0, 1'b1, 1'b1, 8'h31, 32'h0BAD_F00D, 4'hF);
    set_lane(1, 1'b1, 1'b1, 8'h35, 32'h0000_1111, 4'hF);
    drain("cf_ww", 4);
    step("cf_idle");
  endtask

  task automatic test_raw();
    set_lane(0, 1'b1, 1'b1, 8'h20, 32'h55AA55AA, 4'hF);
    step("raw_wr");
    set_lane(0, 1'b1, 1'b0, 8'h20, '0, '0);
    step("raw_rd");
    vectors++;
    if (rsp_rdata[DATA_W-1:0] !== 32'h55AA55AA) begin
      miscompares++;
      $display("FAIL raw_const: got %h expected 55AA55AA", rsp_rdata[DATA_W-1:0]);
    end
    idle();
    step("raw_idle");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2 && mprio != 1; k++) begin
      set_lane(0, 1'b1, 1'b0, 8'h04, '0, '0);
      set_lane(1, 1'b1, 1'b0, 8'h08, '0, '0);
      step("rm_conflict");
    end
    set_lane(0, 1'b1, 1'b0, 8'h04, '0, '0);
    set_lane(1, 1'b1, 1'b0, 8'h08, '0, '0);
    rst = 1'b1;
    step("rm_reset");
    rst = 1'b0;
    step("rm_after");
    req_valid = req_valid & ~last_acc;
    drain("rm_drain", 4);
    step("rm_idle");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 1'b1, 1'b1, ADDR_W'(8'h40 + 2*k), $urandom, 4'hF);
      set_lane(1, 1'b1, 1'b1, ADDR_W'(8'h41 + 2*k), $urandom, 4'hF);
      step("b2b_fill");
    end
    idle();
    last_acc = '1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!req_valid[i] || last_acc[i]) begin
          set_lane(i, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                   ADDR_W'(8'h40 + $urandom_range(0, 15)), $urandom, BYTES'($urandom_range(0, 15)));
        end
      end
      step("b2b");
    end
    req_valid = req_valid & ~last_acc;
    drain("b2b_drain", 4);
    step("b2b_idle");
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    last_acc  = '0;
    for (int i = 0; i < NUM_LANES; i++) last_rd[i] = '0;
    test_reset();
    test_parallel();
    test_byte_enables();
    test_conflict();
    test_raw();
    test_reset_mid();
    test_back_to_back();
    for (int i = 0; i < NUM_LANES; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        miscompares++;
        $display("FAIL outstanding lane%0d: got %0d pending expected 0", i, exp_q[i].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
